audio_stream_ctrl: RTL and testbench

AUDIO_STREAM_CTRL -- requirements
Module: audio_stream_ctrl

---
 rtl/audio_stream_pkg.sv | 32 +++
 rtl/audio_frame_fifo.sv | 59 +++++
 rtl/audio_stream_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_audio_stream_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_stream_pkg.sv
// Shared types and constants for the audio stream controller.
package audio_stream_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = 32;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;

  // Byte assembler position: which byte of the stereo frame comes next.
  typedef enum logic [1:0] {
    B_LL = 2'd0,
    B_LH = 2'd1,
    B_RL = 2'd2,
    B_RH = 2'd3
  } asm_state_t;

  // Playback: PRIME waits for half a FIFO, PLAY pops one frame per tick.
  typedef enum logic {
    PRIME = 1'b0,
    PLAY  = 1'b1
  } play_state_t;

  // Byte order L low, L high, R low, R high, then back to L low.
  function automatic asm_state_t asm_next(input asm_state_t s);
    case (s)
      B_LL:    return B_LH;
      B_LH:    return B_RL;
      B_RL:    return B_RH;
      default: return B_LL;
    endcase
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Single-clock frame FIFO with exact occupancy count.
// A push while full is accepted only if a pop happens in the same cycle.
module audio_frame_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // Storage array; written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally (power-of-2 depth); level tracks push/pop balance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/audio_stream_ctrl.sv
// UART byte stream to stereo DAC sample controller.
// Bytes arrive L low, L high, R low, R high; complete frames are buffered in a
// FIFO and played out one per sample period once the FIFO is half full.
// Optional build macro AUDIO_STREAM_RESYNC_EN adds an inter-byte idle timeout
// that drops a partial frame and realigns the assembler to L low.
//
//   assembler state | meaning
//   B_LL            | expecting left low byte
//   B_LH            | expecting left high byte
//   B_RL            | expecting right low byte
//   B_RH            | expecting right high byte; completes and pushes frame
//
//   playback state  | meaning
//   PRIME           | buffering, outputs held, no pops
//   PLAY            | one pop per sample tick; empty tick -> underrun, PRIME
module audio_stream_ctrl
  import audio_stream_pkg::*;
#(
  parameter int SAMPLE_DIV     = 250,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_byte,
  input  logic                          rx_valid,
  input  logic                          clr_err,
  output logic                          sample_ce,
  output logic [SAMPLE_W-1:0]           sample_l,
  output logic [SAMPLE_W-1:0]           sample_r,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          playing,
  output logic                          underrun,
  output logic                          overrun
);

  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [LW-1:0]    PLAY_THRESH = LW'(FIFO_DEPTH / 2);

  // Sample divider and registered tick.
  logic [DIV_W-1:0] r_div;
  logic             r_sample_ce;
  logic             w_tick;

  // Byte assembler.
  asm_state_t       r_asm_state;
  asm_state_t       w_asm_cur;
  asm_state_t       w_asm_next;
  logic [15:0]      r_l;
  logic [7:0]       r_r_lo;
  logic             w_push;
  logic [FRAME_W-1:0] w_frame;

  // FIFO interface.
  logic [FRAME_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic [LW-1:0]      w_level;

  // Playback.
  play_state_t      r_play_state;
  play_state_t      w_play_next;
  logic             w_pop;
  logic             w_underrun_evt;
  logic             w_overrun_evt;

  logic [SAMPLE_W-1:0] r_sample_l;
  logic [SAMPLE_W-1:0] r_sample_r;
  logic                r_underrun;
  logic                r_overrun;

  assign w_tick  = (r_div == '0);
  assign w_frame = {rx_byte, r_r_lo, r_l};

`ifdef AUDIO_STREAM_RESYNC_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] r_idle;
  logic              w_timeout;

  assign w_timeout = (r_idle == IDLE_W'(TIMEOUT_CYCLES)) && (r_asm_state != B_LL);

  // Idle counter since last byte; saturates at the timeout value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle <= '0;
    end else if (rx_valid) begin
      r_idle <= '0;
    end else if (r_idle != IDLE_W'(TIMEOUT_CYCLES)) begin
      r_idle <= r_idle + 1'b1;
    end
  end
`endif

  // Divider counts SAMPLE_DIV-1 down to 0; the tick registers into sample_ce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div       <= DIV_LOAD;
      r_sample_ce <= 1'b0;
    end else begin
      r_div       <= w_tick ? DIV_LOAD : r_div - 1'b1;
      r_sample_ce <= w_tick;
    end
  end

  // Assembler next state; a timeout realigns before the incoming byte is used.
  always_comb begin
    w_asm_cur  = r_asm_state;
`ifdef AUDIO_STREAM_RESYNC_EN
    if (w_timeout) w_asm_cur = B_LL;
`endif
    w_asm_next = w_asm_cur;
    w_push     = 1'b0;
    if (rx_valid) begin
      w_asm_next = asm_next(w_asm_cur);
      w_push     = (w_asm_cur == B_RH);
    end
  end

  // Assembler state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_asm_state <= B_LL;
    else       r_asm_state <= w_asm_next;
  end

  // Partial-frame byte capture; the R high byte goes straight into the push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l    <= '0;
      r_r_lo <= '0;
    end else if (rx_valid) begin
      case (w_asm_cur)
        B_LL:    r_l[7:0]  <= rx_byte;
        B_LH:    r_l[15:8] <= rx_byte;
        B_RL:    r_r_lo    <= rx_byte;
        default: r_r_lo    <= r_r_lo;
      endcase
    end
  end

  audio_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_frame),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Playback next state, pop request and underrun detection.
  always_comb begin
    w_play_next    = r_play_state;
    w_pop          = 1'b0;
    w_underrun_evt = 1'b0;
    case (r_play_state)
      PRIME: begin
        if (w_level >= PLAY_THRESH) w_play_next = PLAY;
      end
      PLAY: begin
        if (w_tick) begin
          if (w_empty) begin
            w_underrun_evt = 1'b1;
            w_play_next    = PRIME;
          end else begin
            w_pop = 1'b1;
          end
        end
      end
      default: w_play_next = PRIME;
    endcase
  end

  // A full FIFO still accepts a push when a pop frees a slot that cycle.
  assign w_overrun_evt = w_push & w_full & ~w_pop;

  // Playback state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_play_state <= PRIME;
    else       r_play_state <= w_play_next;
  end

  // Output samples load on the same edge that raises sample_ce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample_l <= MIDSCALE;
      r_sample_r <= MIDSCALE;
    end else if (w_pop) begin
      r_sample_l <= w_head[SAMPLE_W-1:0];
      r_sample_r <= w_head[FRAME_W-1:SAMPLE_W];
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_underrun <= w_underrun_evt | (r_underrun & ~clr_err);
      r_overrun  <= w_overrun_evt  | (r_overrun  & ~clr_err);
    end
  end

  assign sample_ce  = r_sample_ce;
  assign sample_l   = r_sample_l;
  assign sample_r   = r_sample_r;
  assign fifo_level = w_level;
  assign playing    = (r_play_state == PLAY);
  assign underrun   = r_underrun;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Testbench for audio_stream_ctrl: frame table, output scoreboard queue,
// and hand-written sequences for overrun, same-cycle push/pop, reset and resync.
module tb_audio_stream_ctrl;

  localparam int SD    = 250;
  localparam int DEPTH = 16;
  localparam int TMO   = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic        clr_err = 1'b0;
  logic        sample_ce;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic [4:0]  fifo_level;
  logic        playing;
  logic        underrun;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int since_rel = 0;

  logic [31:0] q_exp [$];

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          exp_level;
    logic        exp_playing;
  } vec_t;
  vec_t vecs [8];

  audio_stream_ctrl #(
    .SAMPLE_DIV     (SD),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .clr_err    (clr_err),
    .sample_ce  (sample_ce),
    .sample_l   (sample_l),
    .sample_r   (sample_r),
    .fifo_level (fifo_level),
    .playing    (playing),
    .underrun   (underrun),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Independent model of the sample period: ticks land every SD edges after reset.
  always @(posedge clk) begin
    if (reset) since_rel <= 0;
    else       since_rel <= since_rel + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic clr = 1'b0);
    rx_byte  = b;
    rx_valid = 1'b1;
    clr_err  = clr;
    @(negedge clk);
    rx_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_byte(l[7:0]);
    send_byte(l[15:8]);
    send_byte(r[7:0]);
    send_byte(r[15:8]);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // Leaves the bench at the negedge just before a tick edge.
  task automatic wait_pre_tick();
    for (int k = 0; k <= SD; k++) begin
      if (since_rel % SD == SD - 1) return;
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL pre_tick_wait: got no tick slot expected one within %0d cycles", SD);
  endtask

  // Waits for n sample_ce pulses; each compares outputs to the scoreboard head.
  task automatic play_ticks(input int n);
    logic [31:0] e;
    bit          seen;
    for (int t = 0; t < n; t++) begin
      seen = 1'b0;
      for (int k = 0; k < 2 * SD; k++) begin
        @(negedge clk);
        if (sample_ce) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        n_checks++;
        n_fail++;
        $display("FAIL ce_timeout: got no sample_ce expected one within %0d cycles", 2 * SD);
        return;
      end
      check("ce_period", 32'(since_rel % SD), 32'd0);
      if (q_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got sample %h/%h expected no tick", sample_l, sample_r);
      end else begin
        e = q_exp.pop_front();
        check("sample_l", {16'h0, sample_l}, {16'h0, e[15:0]});
        check("sample_r", {16'h0, sample_r}, {16'h0, e[31:16]});
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].l           = 16'h1000 + 16'(i);
      vecs[i].r           = 16'h2000 + 16'(i);
      vecs[i].exp_level   = i + 1;
      vecs[i].exp_playing = (i == 7);
    end

    // ---- reset state and 8-frame playout with terminal underrun ----
    do_reset();
    check("rst_sample_l", {16'h0, sample_l}, 32'h8000);
    check("rst_sample_r", {16'h0, sample_r}, 32'h8000);
    check("rst_ce", {31'h0, sample_ce}, 32'd0);
    check("rst_level", {27'h0, fifo_level}, 32'd0);
    check("rst_playing", {31'h0, playing}, 32'd0);
    check("rst_flags", {30'h0, underrun, overrun}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].l, vecs[i].r);
      q_exp.push_back({vecs[i].r, vecs[i].l});
      check("fill_level", {27'h0, fifo_level}, 32'(vecs[i].exp_level));
      @(negedge clk);
      check("fill_playing", {31'h0, playing}, {31'h0, vecs[i].exp_playing});
    end
    play_ticks(8);
    check("drain_level", {27'h0, fifo_level}, 32'd0);
    check("drain_playing", {31'h0, playing}, 32'd1);
    check("drain_underrun", {31'h0, underrun}, 32'd0);
    q_exp.push_back({16'h2007, 16'h1007});
    play_ticks(1);
    check("ur_flag", {31'h0, underrun}, 32'd1);
    check("ur_prime", {31'h0, playing}, 32'd0);
    pulse_clr();
    check("ur_clear", {31'h0, underrun}, 32'd0);

    // ---- overrun on 17th frame, clear coincident with overrun ----
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_frame(16'h3000 + 16'(i), 16'h4000 + 16'(i));
      if (i < 16) q_exp.push_back({16'h4000 + 16'(i), 16'h3000 + 16'(i)});
    end
    check("ovr_level", {27'h0, fifo_level}, 32'd16);
    check("ovr_flag", {31'h0, overrun}, 32'd1);
    check("ovr_no_ur", {31'h0, underrun}, 32'd0);
    send_byte(8'h99);
    send_byte(8'h99);
    send_byte(8'h99);
    send_byte(8'h99, 1'b1);
    check("ovr_clr_race", {31'h0, overrun}, 32'd1);
    pulse_clr();
    check("ovr_cleared", {31'h0, overrun}, 32'd0);

    // ---- push and pop in the same cycle at full ----
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'h66);
    wait_pre_tick();
    send_byte(8'h66);
    check("full_pp_ce", {31'h0, sample_ce}, 32'd1);
    check("full_pp_level", {27'h0, fifo_level}, 32'd16);
    check("full_pp_ovr", {31'h0, overrun}, 32'd0);
    check("full_pp_out", {sample_r, sample_l}, q_exp.pop_front());
    q_exp.push_back({16'h6666, 16'h5555});
    play_ticks(16);

    // ---- push and pop in the same cycle at empty ----
    send_byte(8'h77);
    send_byte(8'h77);
    send_byte(8'h88);
    wait_pre_tick();
    send_byte(8'h88);
    check("empty_pp_ce", {31'h0, sample_ce}, 32'd1);
    check("empty_pp_level", {27'h0, fifo_level}, 32'd1);
    check("empty_pp_ur", {31'h0, underrun}, 32'd1);
    check("empty_pp_hold", {sample_r, sample_l}, 32'h6666_5555);
    check("empty_pp_prime", {31'h0, playing}, 32'd0);

    // ---- reset between byte 2 and byte 3 ----
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    #1;
    check("midrst_out", {sample_r, sample_l}, 32'h8000_8000);
    check("midrst_level", {27'h0, fifo_level}, 32'd0);
    check("midrst_flags", {30'h0, underrun, overrun}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_frame(16'hA000 + 16'(i), 16'hC000 + 16'(i));
      q_exp.push_back({16'hC000 + 16'(i), 16'hA000 + 16'(i)});
    end
    play_ticks(8);

    // ---- 3 bytes, long idle, then 4 bytes ----
    do_reset();
    q_exp.delete();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (TMO) @(negedge clk);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    check("resync_level", {27'h0, fifo_level}, 32'd1);
`ifdef AUDIO_STREAM_RESYNC_EN
    q_exp.push_back({16'h7766, 16'h5544});
    for (int i = 0; i < 7; i++) begin
      send_frame(16'hD000 + 16'(i), 16'hE000 + 16'(i));
      q_exp.push_back({16'hE000 + 16'(i), 16'hD000 + 16'(i)});
    end
`else
    q_exp.push_back({16'h4433, 16'h2211});
    send_byte(8'h88);
    q_exp.push_back({16'h8877, 16'h6655});
    for (int i = 0; i < 6; i++) begin
      send_frame(16'hD000 + 16'(i), 16'hE000 + 16'(i));
      q_exp.push_back({16'hE000 + 16'(i), 16'hD000 + 16'(i)});
    end
`endif
    check("resync_fill", {27'h0, fifo_level}, 32'd8);
    play_ticks(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
